core_run_ctrl: RTL and testbench

//  Run/halt/step sequencer for the single-cycle core. Sits beside Single_cycle_top and drives a

---
 rtl/core_dbg_pkg.sv | 23 ++
 rtl/core_bkpt_cmp.sv | 30 +++
 rtl/core_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_core_run_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/core_dbg_pkg.sv
// Shared encodings and default widths for the core run/halt/step controller.
package core_dbg_pkg;

  localparam int DEF_XLEN        = 32;
  localparam int DEF_STEP_W      = 16;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_BOOT_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } run_state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RUN  = 2'b01,
    OP_HALT = 2'b10,
    OP_STEP = 2'b11
  } cmd_op_t;

endpackage

// File: rtl/core_bkpt_cmp.sv
// PC breakpoint compare plus the skip flag that lets the breakpoint
// instruction commit once after a resume from HALT.
module core_bkpt_cmp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_bkpt_valid,
  input  logic [XLEN-1:0] i_bkpt_addr,
  input  logic            i_set_skip,
  input  logic            i_clr_skip,
  output logic            o_bp
);

  logic r_skip;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_skip <= 1'b0;
    end else if (i_set_skip) begin
      r_skip <= 1'b1;
    end else if (i_clr_skip) begin
      r_skip <= 1'b0;
    end
  end

  assign o_bp = i_bkpt_valid && (i_pc == i_bkpt_addr) && !r_skip;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/step sequencer producing the commit enable for the single-cycle core.
// Define CORE_BKPT_EN to build in the PC breakpoint stop.
module core_run_ctrl
  import core_dbg_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int STEP_W      = DEF_STEP_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int START_RUN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic [XLEN-1:0]   pc,
  input  logic              bkpt_valid,
  input  logic [XLEN-1:0]   bkpt_addr,
  output logic              core_en,
  output logic              halted,
  output logic [1:0]        state_o,
  output logic              bkpt_hit,
  output logic [CNT_W-1:0]  retired
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);

  // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
  // cmd_ready depends only on state, and the command acts from the next cycle.

  run_state_t        r_state, w_next;
  logic [BOOT_W-1:0] r_boot_cnt;
  logic [STEP_W-1:0] r_step_cnt;
  logic [CNT_W-1:0]  r_retired;
  logic              r_bkpt_hit;
  logic              w_bp_raw, w_bp, w_accept;
  logic              w_core_en, w_cmd_ready, w_load_step, w_set_skip, w_clr_skip;

`ifdef CORE_BKPT_EN
  core_bkpt_cmp #(.XLEN(XLEN)) u_bkpt_cmp (
    .clk          (clk),
    .rst          (rst),
    .i_pc         (pc),
    .i_bkpt_valid (bkpt_valid),
    .i_bkpt_addr  (bkpt_addr),
    .i_set_skip   (w_set_skip),
    .i_clr_skip   (w_clr_skip),
    .o_bp         (w_bp_raw)
  );
`else
  logic w_unused_bkpt;
  assign w_unused_bkpt = ^{bkpt_valid, bkpt_addr, w_set_skip, w_clr_skip};
  assign w_bp_raw      = 1'b0;
`endif

  assign w_bp       = (r_state == ST_RUN) && w_bp_raw;
  assign w_accept   = cmd_valid && w_cmd_ready;
  assign w_clr_skip = (r_state == ST_RUN) && w_core_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_core_en   = 1'b0;
    w_cmd_ready = 1'b0;
    w_load_step = 1'b0;
    w_set_skip  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
          w_next = (START_RUN != 0) ? ST_RUN : ST_HALT;
        end
      end
      ST_RUN: begin
        w_cmd_ready = 1'b1;
        // A breakpoint stop outranks a HALT accepted in the same cycle.
        if (w_bp) begin
          w_next = ST_HALT;
        end else begin
          w_core_en = 1'b1;
          if (w_accept && (cmd_op == OP_HALT)) begin
            w_next = ST_HALT;
          end
        end
      end
      ST_STEP: begin
        w_core_en = 1'b1;
        if (r_step_cnt <= STEP_W'(1)) begin
          w_next = ST_HALT;
        end
      end
      ST_HALT: begin
        w_cmd_ready = 1'b1;
        if (w_accept && (cmd_op == OP_RUN)) begin
          w_next     = ST_RUN;
          w_set_skip = 1'b1;
        end else if (w_accept && (cmd_op == OP_STEP)) begin
          w_next      = ST_STEP;
          w_load_step = 1'b1;
        end
      end
      default: w_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_boot_cnt <= '0;
      r_step_cnt <= '0;
      r_retired  <= '0;
      r_bkpt_hit <= 1'b0;
    end else begin
      if (r_state == ST_BOOT) begin
        r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
      end
      if (w_load_step) begin
        r_step_cnt <= (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
      end else if (r_state == ST_STEP) begin
        r_step_cnt <= r_step_cnt - STEP_W'(1);
      end
      if (w_core_en) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      r_bkpt_hit <= w_bp;
    end
  end

  assign core_en   = w_core_en;
  assign cmd_ready = w_cmd_ready;
  assign halted    = (r_state == ST_HALT);
  assign state_o   = r_state;
  assign bkpt_hit  = r_bkpt_hit;
  assign retired   = r_retired;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios followed by random commands,
// all checked every cycle against a count-based reference model.
module tb_core_run_ctrl;

`ifdef CORE_BKPT_EN
  localparam bit BKPT_EN = 1'b1;
`else
  localparam bit BKPT_EN = 1'b0;
`endif
  localparam int BOOT_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic [31:0] pc;
  logic        bkpt_valid;
  logic [31:0] bkpt_addr;
  logic        core_en;
  logic        halted;
  logic [1:0]  state_o;
  logic        bkpt_hit;
  logic [31:0] retired;

  int tests_run = 0;
  int failed    = 0;

  // Reference model: phase 0 boot, 1 run, 2 step, 3 halt (matches state_o coding)
  int          m_ph;
  int          m_boot;
  int          m_steps;
  bit          m_skip;
  bit          m_hit;
  logic [31:0] m_ret;
  logic [31:0] m_pc;

  core_run_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .pc         (pc),
    .bkpt_valid (bkpt_valid),
    .bkpt_addr  (bkpt_addr),
    .core_en    (core_en),
    .halted     (halted),
    .state_o    (state_o),
    .bkpt_hit   (bkpt_hit),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_boot = 0; m_steps = 0; m_skip = 0; m_hit = 0; m_ret = 0; m_pc = 0;
  endtask

  task automatic drive(input bit r, input bit v, input logic [1:0] op, input logic [15:0] arg);
    rst = r; cmd_valid = v; cmd_op = op; cmd_arg = arg; pc = m_pc;
  endtask

  // Check the current cycle, advance the model across the edge, return at negedge.
  task automatic tick();
    bit bp, en, rdy, acc;
    #1;
    bp  = BKPT_EN && (m_ph == 1) && bkpt_valid && (m_pc == bkpt_addr) && !m_skip;
    en  = ((m_ph == 1) && !bp) || (m_ph == 2);
    rdy = (m_ph == 1) || (m_ph == 3);
    acc = cmd_valid && rdy;
    chk("core_en", {31'b0, core_en}, {31'b0, en});
    chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, rdy});
    chk("halted", {31'b0, halted}, {31'b0, m_ph == 3});
    chk("state_o", {30'b0, state_o}, 32'(m_ph));
    chk("bkpt_hit", {31'b0, bkpt_hit}, {31'b0, m_hit});
    chk("retired", retired, m_ret);
    if (!rst) begin
      model_reset();
    end else begin
      if (en) begin
        m_ret = m_ret + 1;
        m_pc  = m_pc + 4;
      end
      m_hit = bp;
      case (m_ph)
        0: begin
          m_boot++;
          if (m_boot == BOOT_CYCLES) m_ph = 1;
        end
        1: begin
          if (en) m_skip = 0;
          if (bp || (acc && cmd_op == 2'b10)) m_ph = 3;
        end
        2: begin
          m_steps--;
          if (m_steps == 0) m_ph = 3;
        end
        default: begin
          if (acc && cmd_op == 2'b01) begin
            m_ph = 1; m_skip = 1;
          end else if (acc && cmd_op == 2'b11) begin
            m_ph = 2; m_steps = (cmd_arg == 0) ? 1 : int'(cmd_arg);
          end
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 2'b00, 16'd0);
      tick();
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] arg);
    drive(1'b1, 1'b1, op, arg);
    tick();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 2'b00, 16'd0);
      tick();
    end
  endtask

  initial begin
    bkpt_valid = 1'b0;
    bkpt_addr  = 32'h0;
    model_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 16'd0);
    @(posedge clk);
    @(negedge clk);

    // Boot hold then free run
    do_reset(2);
    idle(9);
    // HALT while running, retired must freeze
    send(2'b10, 16'd0);
    idle(3);
    // Single-step by 3, then by 0 (one commit)
    send(2'b11, 16'd3);
    idle(5);
    send(2'b11, 16'd0);
    idle(3);

    // Breakpoint at 0x10, then resume past it
    bkpt_valid = 1'b1;
    bkpt_addr  = 32'h10;
    do_reset(1);
    idle(12);
    send(2'b01, 16'd0);
    idle(4);
    send(2'b10, 16'd0);
    idle(2);

    // Breakpoint and HALT arriving together
    bkpt_addr = 32'h8;
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      if (m_ph == 1 && m_pc == 32'h8) send(2'b10, 16'd0);
      else idle(1);
    end
    // Reset during a 5-step burst
    send(2'b11, 16'd5);
    idle(2);
    do_reset(1);
    idle(6);

    // Random commands, breakpoints and occasional resets
    for (int i = 0; i < 600; i++) begin
      bkpt_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bkpt_addr = m_pc + 32'($urandom_range(0, 4) * 4);
      if ($urandom_range(0, 80) == 0) begin
        do_reset(1);
      end else begin
        drive(1'b1, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
              16'($urandom_range(0, 4)));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
